// File: rtl/ieee754_dot_pkg.sv
// ieee754_dot_pkg
// Shared definitions for the dot-product sequencer that drives ieee754_mac.
//   - FSM state encoding (3-bit localparams)
//   - FP_POS_ZERO: +0.0 pattern. It is held at the widest supported word and
//     sliced to DATA_W by the user (IEEE-754 +0.0 is all-zero at any width).
package ieee754_dot_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;

  localparam int FP_MAX_W = 64;
  localparam logic [FP_MAX_W-1:0] FP_POS_ZERO = '0;

endpackage

// File: rtl/ieee754_dot_seq.sv
// ieee754_dot_seq
// Turns the start/done interface of ieee754_mac into a streaming dot-product
// job: clear the accumulator, feed cfg_len operand pairs one at a time, then
// present the accumulated result on a valid/ready port.
//
// Ports
//   clk_i, rst_ni          clock; synchronous active-low reset
//   go_i, cfg_len_i        job start (sampled in IDLE) and pair count
//   busy_o                 high whenever the FSM is not IDLE
//   in_valid_i/in_ready_o  operand pair handshake, in_a_i/in_b_i
//   mac_clr_o, mac_start_o one-cycle pulses to the MAC
//   mac_op_a_o, mac_op_b_o registered MAC operands
//   mac_done_i, mac_res_i  MAC completion and result
//   out_valid_o/out_ready_i/out_data_o  result handshake
//
// All outputs are flops. Status outputs are computed from the next state so
// they line up with the state register without a decode stage.
module ieee754_dot_seq
  import ieee754_dot_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              go_i,
  input  logic [LEN_W-1:0]  cfg_len_i,
  output logic              busy_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_a_i,
  input  logic [DATA_W-1:0] in_b_i,
  output logic              mac_clr_o,
  output logic              mac_start_o,
  output logic [DATA_W-1:0] mac_op_a_o,
  output logic [DATA_W-1:0] mac_op_b_o,
  input  logic              mac_done_i,
  input  logic [DATA_W-1:0] mac_res_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  logic [2:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              start_d, start_q;
  logic              busy_q, in_ready_q, clr_q, out_valid_q;

  // len is never larger than 2^LEN_W-1, so cnt reaches len before it can wrap.
  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    out_data_d = out_data_q;
    start_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go_i) begin
          if (cfg_len_i != '0) begin
            state_d = ST_CLEAR;
            len_d   = cfg_len_i;
            cnt_d   = '0;
          end else begin
            // Empty job: answer +0.0 directly without touching the MAC.
            state_d    = ST_OUT;
            out_data_d = FP_POS_ZERO[DATA_W-1:0];
          end
        end
      end
      ST_CLEAR: state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (in_valid_i) begin
          // Operands are captured here so they are already stable when the
          // start pulse appears one cycle later, and stay put until done.
          op_a_d  = in_a_i;
          op_b_d  = in_b_i;
          start_d = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mac_done_i) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            out_data_d = mac_res_i;
            state_d    = ST_OUT;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_OUT: if (out_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      out_data_q  <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      clr_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      out_data_q  <= out_data_d;
      start_q     <= start_d;
      busy_q      <= (state_d != ST_IDLE);
      in_ready_q  <= (state_d == ST_ISSUE);
      // CLEAR lasts exactly one cycle, so this is a single pulse per job.
      clr_q       <= (state_d == ST_CLEAR);
      out_valid_q <= (state_d == ST_OUT);
    end
  end

  assign busy_o      = busy_q;
  assign in_ready_o  = in_ready_q;
  assign mac_clr_o   = clr_q;
  assign mac_start_o = start_q;
  assign mac_op_a_o  = op_a_q;
  assign mac_op_b_o  = op_b_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule
